// File: rtl/bit_serial_alu_ctrl.sv
// bit_serial_alu_ctrl -- runs WIDTH-bit ALU operations through one 1-bit ALU
// slice, one bit per clock, LSB first.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request pulse, only looked at while idle
//   op         000 AND, 001 OR, 010 ADD, 011 SUB, 100 NOR, 101 NAND,
//              110 SLT, 111 illegal
//   a, b       operands, captured when a request is accepted
//   busy       high while an operation is running or completing
//   done       one-cycle pulse when result and flags become valid
//   result     operation result, held until the next completion
//   carry_out  carry out of the MSB for ADD/SUB/SLT, else 0
//   overflow   signed overflow for ADD/SUB/SLT, else 0
//   zero       result == 0
//   err        high with done when the op was illegal

// Single-bit ALU slice: optional input inversion, then AND / OR / full add.
module bit_serial_alu_slice (
    input  logic       a_bit,
    input  logic       b_bit,
    input  logic       a_invert,
    input  logic       b_invert,
    input  logic       carry_in,
    input  logic [1:0] sel,        // 00 AND, 01 OR, 10 ADD
    output logic       res_bit,
    output logic       carry_outb
);
    logic aa_s;
    logic bb_s;

    // Combinational slice datapath.
    always_comb begin
        aa_s       = a_bit ^ a_invert;
        bb_s       = b_bit ^ b_invert;
        carry_outb = (aa_s & bb_s) | (carry_in & (aa_s ^ bb_s));
        case (sel)
            2'b00:   res_bit = aa_s & bb_s;
            2'b01:   res_bit = aa_s | bb_s;
            2'b10:   res_bit = aa_s ^ bb_s ^ carry_in;
            default: res_bit = 1'b0;
        endcase
    end
endmodule

module bit_serial_alu_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             err
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b110;
    localparam logic [2:0] OP_ILL = 3'b111;

    // Slice controls for an op, packed as {a_invert, b_invert, sel[1:0], initial carry}.
    function automatic logic [4:0] slice_ctrl(input logic [2:0] o);
        case (o)
            3'b000:  slice_ctrl = {1'b0, 1'b0, 2'b00, 1'b0};  // AND
            3'b001:  slice_ctrl = {1'b0, 1'b0, 2'b01, 1'b0};  // OR
            3'b010:  slice_ctrl = {1'b0, 1'b0, 2'b10, 1'b0};  // ADD
            3'b011:  slice_ctrl = {1'b0, 1'b1, 2'b10, 1'b1};  // SUB
            3'b110:  slice_ctrl = {1'b0, 1'b1, 2'b10, 1'b1};  // SLT
            3'b100:  slice_ctrl = {1'b1, 1'b1, 2'b00, 1'b0};  // NOR = ~a & ~b
            3'b101:  slice_ctrl = {1'b1, 1'b1, 2'b01, 1'b0};  // NAND = ~a | ~b
            default: slice_ctrl = 5'b00000;
        endcase
    endfunction

    logic [1:0]       state_q,     state_d;
    logic [CW-1:0]    cnt_q,       cnt_d;
    logic [WIDTH-1:0] a_sh_q,      a_sh_d;
    logic [WIDTH-1:0] b_sh_q,      b_sh_d;
    logic [WIDTH-1:0] res_sh_q,    res_sh_d;
    logic [2:0]       op_q,        op_d;
    logic             carry_q,     carry_d;
    logic [WIDTH-1:0] result_q,    result_d;
    logic             carry_out_q, carry_out_d;
    logic             overflow_q,  overflow_d;
    logic             zero_q,      zero_d;
    logic             err_q,       err_d;
    logic             done_q,      done_d;
    logic             busy_q,      busy_d;

    logic [4:0]       ctrl_s;
    logic             slice_res_s;
    logic             slice_cout_s;
    logic             is_arith_s;
    logic             ovf_raw_s;
    logic [WIDTH-1:0] final_res_s;

    // Slice controls follow the latched op for the whole run.
    always_comb begin
        ctrl_s     = slice_ctrl(op_q);
        is_arith_s = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_SLT);
    end

    bit_serial_alu_slice u_slice (
        .a_bit      (a_sh_q[0]),
        .b_bit      (b_sh_q[0]),
        .a_invert   (ctrl_s[4]),
        .b_invert   (ctrl_s[3]),
        .carry_in   (carry_q),
        .sel        (ctrl_s[2:1]),
        .res_bit    (slice_res_s),
        .carry_outb (slice_cout_s)
    );

    // Final-bit result assembly; carry_q is the carry into the MSB at the last bit.
    always_comb begin
        ovf_raw_s = carry_q ^ slice_cout_s;
        if (op_q == OP_SLT) begin
            // Signed less-than: sign of the difference corrected by overflow.
            final_res_s = {{(WIDTH-1){1'b0}}, slice_res_s ^ ovf_raw_s};
        end else begin
            final_res_s = {slice_res_s, res_sh_q[WIDTH-1:1]};
        end
    end

    // Next-state and datapath logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        res_sh_d    = res_sh_q;
        op_d        = op_q;
        carry_d     = carry_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        zero_d      = zero_q;
        err_d       = err_q;
        done_d      = 1'b0;
        busy_d      = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                    if (op == OP_ILL) begin
                        state_d     = ST_DONE;
                        done_d      = 1'b1;
                        result_d    = '0;
                        carry_out_d = 1'b0;
                        overflow_d  = 1'b0;
                        zero_d      = 1'b1;
                        err_d       = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        a_sh_d  = a;
                        b_sh_d  = b;
                        op_d    = op;
                        cnt_d   = '0;
                        carry_d = slice_ctrl(op)[0];
                        err_d   = 1'b0;
                    end
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                res_sh_d = {slice_res_s, res_sh_q[WIDTH-1:1]};
                carry_d  = slice_cout_s;
                if (cnt_q == LAST) begin
                    state_d     = ST_DONE;
                    done_d      = 1'b1;
                    result_d    = final_res_s;
                    carry_out_d = is_arith_s & slice_cout_s;
                    overflow_d  = is_arith_s & ovf_raw_s;
                    zero_d      = (final_res_s == '0);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            res_sh_q    <= '0;
            op_q        <= 3'b000;
            carry_q     <= 1'b0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            res_sh_q    <= res_sh_d;
            op_q        <= op_d;
            carry_q     <= carry_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
            err_q       <= err_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;
    assign err       = err_q;
endmodule
